// File: rtl/sao_pkg.sv
// Shared definitions for the SAO edge-offset estimator: statistic widths,
// cost width helper and the controller state encoding.
package sao_pkg;

   localparam int NUM_ACCU_LEN  = 9;
   localparam int DIFF_CLIP_BIT = 4;
   localparam int MAG_MAX       = 7;

   // Signed cost width minus one, derived from the statistic widths.
   function automatic int cost_len_of(input int accu_len, input int clip_bit);
      return accu_len + clip_bit + 8;
   endfunction

   localparam int COST_LEN = cost_len_of(NUM_ACCU_LEN, DIFF_CLIP_BIT);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      PICK,
      DONE
   } sao_state_e;

endpackage

// File: rtl/sao_rnd_div3.sv
// Serial rounding divider for offset magnitudes: q = min(7, floor(N/D)).
// Step 0 (start) latches operands and flags saturation, steps 1-3 resolve
// quotient bits 2..1 by restoring compare and bit 0 combinationally, so q is
// valid during the fourth cycle.
module sao_rnd_div3
   import sao_pkg::*;
#(
   parameter int dw = 16
) (
   input  logic          clk_slow,
   input  logic          rst_n,
   input  logic          start,
   input  logic [dw-1:0] N,
   input  logic [dw-1:0] D,
   output logic [2:0]    q,
   output logic          valid
);

   logic [1:0]    phase;
   logic [dw-1:0] rem;
   logic [dw-1:0] den;
   logic          sat;
   logic [1:0]    q_hi;
   logic          q_lo;
   logic [dw+2:0] n_x;
   logic [dw+2:0] rem_x;
   logic [dw+2:0] den2_x;
   logic [dw+2:0] den4_x;
   logic [dw+2:0] den8_x;

   // Widened operands for overflow-free compares, last quotient bit and result.
   always_comb begin
      n_x    = {3'b000, N};
      rem_x  = {3'b000, rem};
      den2_x = {2'b00, den, 1'b0};
      den4_x = {1'b0, den, 2'b00};
      den8_x = {D, 3'b000};
      q_lo   = (rem >= den);
      valid  = (phase == 2'd3);
      q      = sat ? 3'(MAG_MAX) : {q_hi, q_lo};
   end

   // Step sequencer: latch and saturation check, then two restoring steps.
   always_ff @(posedge clk_slow) begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge value of its neighbours, as real flops do.
      if (!rst_n) begin
         phase <= 2'd0;
         rem   <= '0;
         den   <= '0;
         sat   <= 1'b0;
         q_hi  <= 2'b00;
      end else begin
         case (phase)
            2'd0: begin
               if (start) begin
                  rem   <= N;
                  den   <= D;
                  sat   <= (n_x >= den8_x);
                  q_hi  <= 2'b00;
                  phase <= 2'd1;
               end
            end
            2'd1: begin
               if (rem_x >= den4_x) begin
                  rem     <= rem - den4_x[dw-1:0];
                  q_hi[1] <= 1'b1;
               end
               phase <= 2'd2;
            end
            2'd2: begin
               if (rem_x >= den2_x) begin
                  rem     <= rem - den2_x[dw-1:0];
                  q_hi[0] <= 1'b1;
               end
               phase <= 2'd3;
            end
            default: phase <= 2'd0;
         endcase
      end
   end

endmodule

// File: rtl/sao_eo_offset_est.sv
// SAO edge-offset estimator: snapshots per-category statistics on start,
// walks the 16 entries serially (4 cycles each) through the rounding divider,
// accumulates the distortion delta per EO class and picks the cheapest class.
module sao_eo_offset_est
   import sao_pkg::*;
#(
   parameter int num_accu_len  = NUM_ACCU_LEN,
   parameter int diff_clip_bit = DIFF_CLIP_BIT,
   parameter int n_eo_type     = 4,
   parameter int n_category    = 4,
   parameter int cost_len      = cost_len_of(num_accu_len, diff_clip_bit)
) (
   input  logic                                      clk_slow,
   input  logic                                      rst_n,
   input  logic                                      start,
   input  logic signed [num_accu_len+diff_clip_bit:0] sum_blk_CTU_DCI [n_eo_type][n_category],
   input  logic        [num_accu_len:0]               num_blk_CTU_DCI [n_eo_type][n_category],
   output logic                                      busy,
   output logic                                      done,
   output logic signed [3:0]                         eo_offset [n_eo_type][n_category],
   output logic signed [cost_len:0]                  eo_cost [n_eo_type],
   output logic        [1:0]                         best_eo_type
);

   localparam int sw = num_accu_len + diff_clip_bit + 1;
   localparam int nw = num_accu_len + 1;
   localparam int dw = sw + 2;
   localparam int cw = cost_len + 1;
   localparam int tw = (n_eo_type > 1) ? $clog2(n_eo_type) : 1;
   localparam int kw = (n_category > 1) ? $clog2(n_category) : 1;

   sao_state_e state;
   logic [1:0]    step;
   logic [tw-1:0] typ_idx;
   logic [kw-1:0] cat_idx;
   logic          accept;
   logic          last_entry;

   logic signed [sw-1:0] snap_sum [n_eo_type][n_category];
   logic        [nw-1:0] snap_num [n_eo_type][n_category];
   logic signed [3:0]    work_offset [n_eo_type][n_category];
   logic signed [cw-1:0] work_cost [n_eo_type];

   logic          div_start;
   logic [dw-1:0] div_n;
   logic [dw-1:0] div_d;
   logic [2:0]    div_q;
   logic          div_valid;

   logic signed [sw-1:0] s_cur;
   logic        [nw-1:0] n_cur;
   logic        [sw-1:0] abs_s;
   logic                 pos_cat;
   logic                 force_zero;
   logic        [2:0]    mag;
   logic signed [3:0]    ent_offset;
   logic        [cw-1:0] t_quad;
   logic        [cw-1:0] t_lin;
   logic signed [cw-1:0] ent_delta;

   logic        [1:0]    min_idx;
   logic signed [cw-1:0] min_val;

   assign accept     = (state == IDLE) && start;
   assign div_start  = (state == CALC) && (step == 2'd0);
   assign last_entry = (typ_idx == tw'(n_eo_type - 1)) &&
                       (cat_idx == kw'(n_category - 1)) && (step == 2'd3);

   // Capture the statistics at start acceptance; the run only sees this copy.
   always_ff @(posedge clk_slow) begin
      // NOTE: the snapshot is a plain data store fully written before use, so
      // it has no reset; clearing it would only add reset fan-out.
      if (accept) begin
         for (int t = 0; t < n_eo_type; t++) begin
            for (int c = 0; c < n_category; c++) begin
               snap_sum[t][c] <= sum_blk_CTU_DCI[t][c];
               snap_num[t][c] <= num_blk_CTU_DCI[t][c];
            end
         end
      end
   end

   // Per-entry datapath: divider operands, sign rules, offset and delta.
   always_comb begin
      // NOTE: every variable gets a value before any condition so no path
      // leaves one unassigned, which would infer a latch.
      s_cur      = snap_sum[typ_idx][cat_idx];
      n_cur      = snap_num[typ_idx][cat_idx];
      abs_s      = s_cur[sw-1] ? -s_cur : s_cur;
      pos_cat    = (int'(cat_idx) < 2);
      div_n      = dw'({abs_s, 1'b0}) + dw'(n_cur);
      div_d      = dw'({n_cur, 1'b0});
      force_zero = (n_cur == '0);
      if (pos_cat) begin
         if (s_cur[sw-1] || (s_cur == '0)) force_zero = 1'b1;
      end else begin
         if (!s_cur[sw-1]) force_zero = 1'b1;
      end
      mag        = force_zero ? 3'd0 : div_q;
      ent_offset = pos_cat ? $signed({1'b0, mag}) : -$signed({1'b0, mag});
      t_quad     = cw'(n_cur) * cw'(mag) * cw'(mag);
      t_lin      = cw'({abs_s, 1'b0}) * cw'(mag);
      ent_delta  = $signed(t_quad) - $signed(t_lin);
   end

   // Lowest-cost class; strict compare keeps the lowest index on ties.
   always_comb begin
      min_idx = 2'd0;
      min_val = work_cost[0];
      for (int i = 1; i < n_eo_type; i++) begin
         if (work_cost[i] < min_val) begin
            min_idx = 2'(i);
            min_val = work_cost[i];
         end
      end
   end

   sao_rnd_div3 #(
      .dw(dw)
   ) u_div (
      .clk_slow(clk_slow),
      .rst_n   (rst_n),
      .start   (div_start),
      .N       (div_n),
      .D       (div_d),
      .q       (div_q),
      .valid   (div_valid)
   );

   // Controller: entry walk, cost accumulation and result publication.
   always_ff @(posedge clk_slow) begin
      if (!rst_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         best_eo_type <= 2'd0;
         step         <= 2'd0;
         typ_idx      <= '0;
         cat_idx      <= '0;
         for (int t = 0; t < n_eo_type; t++) begin
            eo_cost[t]   <= '0;
            work_cost[t] <= '0;
            for (int c = 0; c < n_category; c++) begin
               eo_offset[t][c]   <= '0;
               work_offset[t][c] <= '0;
            end
         end
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  for (int t = 0; t < n_eo_type; t++) work_cost[t] <= '0;
                  step    <= 2'd0;
                  typ_idx <= '0;
                  cat_idx <= '0;
                  busy    <= 1'b1;
                  state   <= CALC;
               end
            end
            CALC: begin
               if (div_valid) begin
                  work_offset[typ_idx][cat_idx] <= ent_offset;
                  work_cost[typ_idx]            <= work_cost[typ_idx] + ent_delta;
               end
               step <= step + 2'd1;
               if (step == 2'd3) begin
                  if (cat_idx == kw'(n_category - 1)) begin
                     cat_idx <= '0;
                     if (!last_entry) typ_idx <= typ_idx + tw'(1);
                  end else begin
                     cat_idx <= cat_idx + kw'(1);
                  end
               end
               if (last_entry) state <= PICK;
            end
            PICK: begin
               for (int t = 0; t < n_eo_type; t++) begin
                  eo_cost[t] <= work_cost[t];
                  for (int c = 0; c < n_category; c++) eo_offset[t][c] <= work_offset[t][c];
               end
               best_eo_type <= min_idx;
               done         <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
